game_layer_compositor: RTL and testbench

- Parametrised successor to the top-level priority RGB select and play-enable latch.
- Combines a game-state FSM (start/play/pause/game-over/win) with an N-layer sprite compositor that honours a transparency colour key.
- Produces one registered pixel per clk for the VGA driver, 2-cycle latency.
- Sits between the sprite/background judge modules and the VGA module; generates play_rst to reinitialise game elements.

---
 rtl/game_layer_compositor.sv | 177 +++++++++++++++++
 tb/tb_game_layer_compositor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/game_layer_compositor.sv
// Game-state FSM plus an N-layer colour-keyed sprite compositor feeding the VGA driver.
// Two-stage pixel pipeline: layer select, then pause dimming and visible-area masking.
module game_layer_compositor #(
  parameter int unsigned       N_LAYERS  = 8,
  parameter int unsigned       RGB_W     = 12,
  parameter logic [RGB_W-1:0]  KEY_RGB   = 12'h0F0,
  parameter int unsigned       DIM_SHIFT = 1,
  localparam int unsigned      SEL_W     = $clog2(N_LAYERS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enter,
  input  logic                      pause,
  input  logic                      player_dead,
  input  logic                      boss_dead,
  input  logic                      de,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [RGB_W-1:0]          background_rgb,
  input  logic [RGB_W-1:0]          start_rgb,
  input  logic [RGB_W-1:0]          over_rgb,
  input  logic [RGB_W-1:0]          win_rgb,
  output logic [RGB_W-1:0]          pix_rgb,
  output logic [SEL_W-1:0]          pix_sel,
  output logic [2:0]                game_state,
  output logic                      play_en,
  output logic                      play_rst
);

  localparam int unsigned CH_W = RGB_W / 3;
  localparam logic [SEL_W-1:0] SelNone = SEL_W'(N_LAYERS);

  typedef enum logic [2:0] {
    StStart = 3'd0,
    StPlay  = 3'd1,
    StPause = 3'd2,
    StOver  = 3'd3,
    StWin   = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   enter_q, pause_q;
  logic   play_en_q, play_en_d;
  logic   play_rst_q, play_rst_d;
  logic   enter_rise, pause_rise;

  // Stage 1 registers
  logic [RGB_W-1:0] s1_rgb_q, s1_rgb_d;
  logic [SEL_W-1:0] s1_sel_q, s1_sel_d;
  logic             s1_dim_q, s1_dim_d;
  logic             s1_de_q;

  // Stage 2 registers
  logic [RGB_W-1:0] pix_rgb_q, pix_rgb_d;
  logic [SEL_W-1:0] pix_sel_q, pix_sel_d;

  logic             hit_found;
  logic [SEL_W-1:0] hit_idx;
  logic [RGB_W-1:0] hit_rgb;
  logic [RGB_W-1:0] dim_rgb;

  assign enter_rise = enter & ~enter_q;
  assign pause_rise = pause & ~pause_q;

  always_comb begin
    state_d    = state_q;
    play_rst_d = 1'b0;
    unique case (state_q)
      StStart: begin
        if (enter_rise) begin
          state_d    = StPlay;
          play_rst_d = 1'b1;
        end
      end
      StPlay: begin
        // Player death takes precedence over a simultaneous boss kill.
        if (player_dead)     state_d = StOver;
        else if (boss_dead)  state_d = StWin;
        else if (pause_rise) state_d = StPause;
      end
      StPause: begin
        if (pause_rise) state_d = StPlay;
      end
      StOver, StWin: begin
        if (enter_rise) state_d = StStart;
      end
      default: state_d = StStart;
    endcase
    play_en_d = (state_q == StPlay);
  end

  // Lowest-index present layer wins; key-coloured pixels count as absent.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = SelNone;
    hit_rgb   = background_rgb;
    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      if (!hit_found && layer_en[i] && (layer_rgb[i*RGB_W +: RGB_W] != KEY_RGB)) begin
        hit_found = 1'b1;
        hit_idx   = SEL_W'(i);
        hit_rgb   = layer_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  always_comb begin
    s1_rgb_d = hit_rgb;
    s1_sel_d = hit_idx;
    s1_dim_d = (state_q == StPause);
    unique case (state_q)
      StStart: begin
        s1_rgb_d = start_rgb;
        s1_sel_d = SelNone;
      end
      StOver: begin
        s1_rgb_d = over_rgb;
        s1_sel_d = SelNone;
      end
      StWin: begin
        s1_rgb_d = win_rgb;
        s1_sel_d = SelNone;
      end
      default: ;
    endcase
  end

  always_comb begin
    dim_rgb = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      dim_rgb[c*CH_W +: CH_W] = s1_rgb_q[c*CH_W +: CH_W] >> DIM_SHIFT;
    end
  end

  always_comb begin
    pix_rgb_d = '0;
    pix_sel_d = SelNone;
    if (s1_de_q) begin
      pix_rgb_d = s1_dim_q ? dim_rgb : s1_rgb_q;
      pix_sel_d = s1_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStart;
      enter_q    <= 1'b0;
      pause_q    <= 1'b0;
      play_en_q  <= 1'b0;
      play_rst_q <= 1'b0;
      s1_rgb_q   <= '0;
      s1_sel_q   <= SelNone;
      s1_dim_q   <= 1'b0;
      s1_de_q    <= 1'b0;
      pix_rgb_q  <= '0;
      pix_sel_q  <= SelNone;
    end else begin
      state_q    <= state_d;
      enter_q    <= enter;
      pause_q    <= pause;
      play_en_q  <= play_en_d;
      play_rst_q <= play_rst_d;
      s1_rgb_q   <= s1_rgb_d;
      s1_sel_q   <= s1_sel_d;
      s1_dim_q   <= s1_dim_d;
      s1_de_q    <= de;
      pix_rgb_q  <= pix_rgb_d;
      pix_sel_q  <= pix_sel_d;
    end
  end

  assign pix_rgb    = pix_rgb_q;
  assign pix_sel    = pix_sel_q;
  assign game_state = state_q;
  assign play_en    = play_en_q;
  assign play_rst   = play_rst_q;

endmodule

// File: tb/tb_game_layer_compositor.sv
// Scoreboard bench for game_layer_compositor: a behavioural game/pixel model predicts every cycle.
module tb_game_layer_compositor;

  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        rst, enter, pause, player_dead, boss_dead, de;
  logic [7:0]  layer_en;
  logic [95:0] layer_rgb;
  logic [11:0] background_rgb, start_rgb, over_rgb, win_rgb;
  logic [11:0] pix_rgb;
  logic [3:0]  pix_sel;
  logic [2:0]  game_state;
  logic        play_en, play_rst;

  game_layer_compositor dut (
    .clk            (clk),
    .rst            (rst),
    .enter          (enter),
    .pause          (pause),
    .player_dead    (player_dead),
    .boss_dead      (boss_dead),
    .de             (de),
    .layer_en       (layer_en),
    .layer_rgb      (layer_rgb),
    .background_rgb (background_rgb),
    .start_rgb      (start_rgb),
    .over_rgb       (over_rgb),
    .win_rgb        (win_rgb),
    .pix_rgb        (pix_rgb),
    .pix_sel        (pix_sel),
    .game_state     (game_state),
    .play_en        (play_en),
    .play_rst       (play_rst)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rst_pulses;

  // Model state
  int   m_state;
  logic m_enter_q, m_pause_q, m_play_en, m_play_rst;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_pix(output logic [11:0] rgb, output logic [3:0] sel);
    rgb = 12'h000;
    sel = 4'd8;
    if (de) begin
      case (m_state)
        0: rgb = start_rgb;
        3: rgb = over_rgb;
        4: rgb = win_rgb;
        default: begin
          rgb = background_rgb;
          for (int i = NL - 1; i >= 0; i--) begin
            if (layer_en[i] && layer_rgb[i*12 +: 12] != 12'h0F0) begin
              rgb = layer_rgb[i*12 +: 12];
              sel = 4'(i);
            end
          end
          if (m_state == 2) rgb = (rgb >> 1) & 12'h777;
        end
      endcase
    end
  endtask

  task automatic step();
    logic [11:0] er;
    logic [3:0]  es;
    logic [15:0] e;
    logic        ent_r, pau_r;
    int          nxt;
    if (rst) begin
      er = 12'h000;
      es = 4'd8;
      if (exp_q.size() > 0) exp_q[$] = {12'h000, 4'd8};
    end else begin
      model_pix(er, es);
    end
    exp_q.push_back({er, es});
    @(posedge clk);
    #1;
    if (rst) begin
      m_state = 0; m_play_en = 0; m_play_rst = 0; m_enter_q = 0; m_pause_q = 0;
    end else begin
      ent_r = enter & ~m_enter_q;
      pau_r = pause & ~m_pause_q;
      nxt = m_state;
      m_play_rst = 0;
      case (m_state)
        0: if (ent_r) begin nxt = 1; m_play_rst = 1; end
        1: if (player_dead) nxt = 3; else if (boss_dead) nxt = 4; else if (pau_r) nxt = 2;
        2: if (pau_r) nxt = 1;
        default: if (ent_r) nxt = 0;
      endcase
      m_play_en = (m_state == 1);
      m_state   = nxt;
      m_enter_q = enter;
      m_pause_q = pause;
    end
    if (play_rst === 1'b1) rst_pulses++;
    check("game_state", 32'(game_state), 32'(m_state));
    check("play_en", 32'(play_en), 32'(m_play_en));
    check("play_rst", 32'(play_rst), 32'(m_play_rst));
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check("pix_rgb", 32'(pix_rgb), 32'(e[15:4]));
      check("pix_sel", 32'(pix_sel), 32'(e[3:0]));
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1; enter = 0; pause = 0; player_dead = 0; boss_dead = 0; de = 1;
    layer_en = '0; layer_rgb = '0;
    background_rgb = 12'h123; start_rgb = 12'hF00; over_rgb = 12'h0AA; win_rgb = 12'h5C3;
    m_state = 0; m_enter_q = 0; m_pause_q = 0; m_play_en = 0; m_play_rst = 0;
    steps(3);
    rst = 0;
    steps(3);

    // Hold enter: exactly one play_rst
    rst_pulses = 0;
    enter = 1;
    steps(5);
    enter = 0;
    steps(2);
    check("play_rst_count", 32'(rst_pulses), 32'd1);

    // Keyed layer 1 falls through to layer 2
    layer_en = 8'b0000_0110;
    layer_rgb[12 +: 12] = 12'h0F0;
    layer_rgb[24 +: 12] = 12'hABC;
    steps(4);
    check("keyed_sel", 32'(pix_sel), 32'd2);

    // Background, then masked by de
    layer_en = '0;
    steps(3);
    de = 0;
    steps(3);
    check("de_mask", 32'(pix_rgb), 32'h0);
    de = 1;

    // Pause dimming and resume without play_rst
    layer_en = 8'b0000_0001;
    layer_rgb[0 +: 12] = 12'hFFF;
    pause = 1; step(); pause = 0;
    steps(3);
    check("paused_rgb", 32'(pix_rgb), 32'h777);
    player_dead = 1; boss_dead = 1;
    steps(2);
    player_dead = 0; boss_dead = 0;
    pause = 1; step(); pause = 0;
    steps(2);

    // Simultaneous deaths go to OVER; enter returns to START
    player_dead = 1; boss_dead = 1; step();
    player_dead = 0; boss_dead = 0;
    steps(3);
    check("over_state", 32'(game_state), 32'd3);
    enter = 1; step(); enter = 0;
    steps(3);

    // Boss kill then mid-frame reset
    enter = 1; step(); enter = 0;
    steps(2);
    boss_dead = 1; step(); boss_dead = 0;
    steps(3);
    rst = 1; step(); rst = 0;
    steps(4);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      de          = ($urandom_range(0, 9) != 0);
      layer_en    = 8'($urandom());
      for (int i = 0; i < NL; i++)
        layer_rgb[i*12 +: 12] = ($urandom_range(0, 3) == 0) ? 12'h0F0 : 12'($urandom());
      background_rgb = 12'($urandom());
      start_rgb      = 12'($urandom());
      over_rgb       = 12'($urandom());
      win_rgb        = 12'($urandom());
      if ($urandom_range(0, 4) == 0) enter = ~enter;
      if ($urandom_range(0, 3) == 0) pause = ~pause;
      player_dead = ($urandom_range(0, 39) == 0);
      boss_dead   = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; player_dead = 0; boss_dead = 0;
    steps(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
